// File: rtl/ps2_receiver_pkg.sv
// ps2_pkg: shared FSM states and PS/2 frame constants for the PS/2 receiver.
package ps2_pkg;
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;
    localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
    localparam logic       PS2_START_BIT  = 1'b0;
    localparam logic       PS2_STOP_BIT   = 1'b1;
    localparam int         PS2_DATA_BITS  = 8;
endpackage

// File: rtl/ps2_receiver_if.sv
// ps2_receiver_if: raw PS/2 pins plus the decoded scan-code outputs.
interface ps2_receiver_if;
    logic       ps2_clock;
    logic       ps2_data;
    logic [7:0] ps2_out;
    logic       ps2_key_pressed;
    logic       parity_error;
    logic       frame_error;
    logic       rx_busy;
    modport master (output ps2_clock, ps2_data,
                    input  ps2_out, ps2_key_pressed, parity_error, frame_error, rx_busy);
    modport slave  (input  ps2_clock, ps2_data,
                    output ps2_out, ps2_key_pressed, parity_error, frame_error, rx_busy);
endinterface

// File: rtl/ps2_receiver_clock_filter.sv
// ps2_clock_filter: pin synchronizers, PS/2 clock glitch filter and falling-edge pulse.
module ps2_clock_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic ps2_clock_i,
    input  logic ps2_data_i,
    output logic fall_o,
    output logic data_o
);
    localparam int CW = $clog2(FILTER_LEN + 1);
    logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
    logic                   level_q, level_d, fall_q, differ, flip;
    logic [CW-1:0]          cnt_q, cnt_d;
    always_comb begin
        differ  = clk_sync_q[SYNC_STAGES-1] != level_q;
        flip    = differ && cnt_q == CW'(FILTER_LEN - 1);
        cnt_d   = (!differ || flip) ? '0 : cnt_q + 1'b1;
        level_d = flip ? ~level_q : level_q;
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            level_q    <= 1'b1;
            cnt_q      <= '0;
            fall_q     <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clock_i};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_data_i};
            level_q    <= level_d;
            cnt_q      <= cnt_d;
            fall_q     <= level_q & ~level_d;
        end
    end
    assign fall_o = fall_q;
    assign data_o = dat_sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/ps2_receiver.sv
// ps2_receiver: PS/2 frame deframer with parity/stop checking and mid-frame timeout.
// Define PS2_BREAK_FILTER_EN to swallow 0xF0 break codes and the byte that follows them.
module ps2_receiver
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 12500
) (
    input  logic           clock,
    input  logic           reset,
    ps2_receiver_if.slave  bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic          fall, data, accept, parity_ok;
    ps2_state_e    state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [7:0]    shift_q, shift_d, out_q, out_d;
    logic          par_q, par_d, key_q, key_d, perr_q, perr_d, ferr_q, ferr_d;
    logic [TW-1:0] tmo_q, tmo_d;
`ifdef PS2_BREAK_FILTER_EN
    logic          brk_q, brk_d;
`endif
    ps2_clock_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filter (
        .clock       (clock),
        .reset       (reset),
        .ps2_clock_i (bus.ps2_clock),
        .ps2_data_i  (bus.ps2_data),
        .fall_o      (fall),
        .data_o      (data)
    );
    assign parity_ok = ^{shift_q, par_q};
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        out_d   = out_q;
        key_d   = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        accept  = 1'b0;
`ifdef PS2_BREAK_FILTER_EN
        brk_d   = brk_q;
`endif
        if (fall) begin
            case (state_q)
                IDLE: if (data == PS2_START_BIT) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
                DATA: begin
                    shift_d[cnt_q] = data;
                    cnt_d          = cnt_q + 1'b1;
                    state_d        = (cnt_q == 3'(PS2_DATA_BITS - 1)) ? PARITY : DATA;
                end
                PARITY: begin
                    par_d   = data;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    perr_d  = !parity_ok;
                    ferr_d  = parity_ok && data != PS2_STOP_BIT;
                    accept  = parity_ok && data == PS2_STOP_BIT;
                end
            endcase
        end else if (state_q != IDLE && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d = IDLE;
        end
`ifdef PS2_BREAK_FILTER_EN
        if (accept) begin
            if (shift_q == PS2_BREAK_CODE) brk_d = 1'b1;
            else if (brk_q) brk_d = 1'b0;
            else begin
                out_d = shift_q;
                key_d = 1'b1;
            end
        end
`else
        out_d = accept ? shift_q : out_q;
        key_d = accept;
`endif
        tmo_d = (fall || state_d == IDLE) ? '0 : tmo_q + 1'b1;
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            out_q   <= '0;
            key_q   <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            tmo_q   <= '0;
`ifdef PS2_BREAK_FILTER_EN
            brk_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            out_q   <= out_d;
            key_q   <= key_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            tmo_q   <= tmo_d;
`ifdef PS2_BREAK_FILTER_EN
            brk_q   <= brk_d;
`endif
        end
    end
    assign bus.ps2_out         = out_q;
    assign bus.ps2_key_pressed = key_q;
    assign bus.parity_error    = perr_q;
    assign bus.frame_error     = ferr_q;
    assign bus.rx_busy         = state_q != IDLE;
endmodule

// File: tb/tb_ps2_receiver.sv
// tb_ps2_receiver: directed and random PS/2 frames checked against a frame-level outcome model.
module tb_ps2_receiver;
    localparam int SYNC = 2, FL = 4, TMO = 12500, HALF = 10;
    logic clock = 1'b0;
    logic reset = 1'b1;
    ps2_receiver_if bus();
    ps2_receiver #(.SYNC_STAGES(SYNC), .FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );
    always #5 clock = ~clock;

    int cyc = 0, keys = 0, perrs = 0, ferrs = 0, multi = 0, key_cyc = 0, stop_cyc = 0;
    int compared = 0, mismatched = 0;
    logic [2:0] prev_s = 3'b000;
    logic [7:0] m_out = 8'h00;
    int m_keys = 0, m_perr = 0, m_ferr = 0;
    bit m_brk = 1'b0;

    always @(posedge clock) cyc++;

    // Strobe monitor: counts each strobe kind and flags overlapping or back-to-back strobes.
    always @(negedge clock) begin
        logic [2:0] s;
        s = {bus.ps2_key_pressed === 1'b1, bus.parity_error === 1'b1, bus.frame_error === 1'b1};
        if (s[2]) begin keys++; key_cyc = cyc; end
        if (s[1]) perrs++;
        if (s[0]) ferrs++;
        if ($countones(s) > 1 || (s != 0 && prev_s != 0)) multi++;
        prev_s = s;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc_wait(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send(input logic [7:0] b, input bit pflip, input bit stopv, input int nbits, input int glitch_bit);
        logic [10:0] f;
        f = {stopv, ~^b ^ pflip, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            bus.ps2_data = f[i];
            if (i == glitch_bit) begin
                cyc_wait(2);
                bus.ps2_clock = 1'b0;
                cyc_wait(FL - 1);
                bus.ps2_clock = 1'b1;
                cyc_wait(HALF - 2 - (FL - 1));
            end else cyc_wait(HALF);
            bus.ps2_clock = 1'b0;
            if (i == 10) stop_cyc = cyc;
            cyc_wait(HALF);
            bus.ps2_clock = 1'b1;
        end
        bus.ps2_data = 1'b1;
    endtask

    // Frame-level outcome: odd parity over data+parity, then stop bit, then break filtering.
    task automatic model(input logic [7:0] b, input bit pflip, input bit stopv);
        if (pflip) m_perr++;
        else if (!stopv) m_ferr++;
        else begin
`ifdef PS2_BREAK_FILTER_EN
            if (b == 8'hF0) m_brk = 1'b1;
            else if (m_brk) m_brk = 1'b0;
            else begin m_out = b; m_keys++; end
`else
            m_out = b;
            m_keys++;
`endif
        end
    endtask

    task automatic check_frame(input string tag);
        check({tag, ".out"}, bus.ps2_out, m_out);
        check({tag, ".keys"}, keys, m_keys);
        check({tag, ".perr"}, perrs, m_perr);
        check({tag, ".ferr"}, ferrs, m_ferr);
        check({tag, ".busy"}, bus.rx_busy, 0);
        check({tag, ".multi"}, multi, 0);
    endtask

    task automatic frame(input string tag, input logic [7:0] b, input bit pflip, input bit stopv, input int glitch_bit);
        send(b, pflip, stopv, 11, glitch_bit);
        model(b, pflip, stopv);
        cyc_wait(30);
        check_frame(tag);
    endtask

    initial begin
        logic [7:0] b;
        int kind, g;
        bus.ps2_clock = 1'b1;
        bus.ps2_data  = 1'b1;
        #2 reset = 1'b0;
        cyc_wait(3);
        check("rst.out", bus.ps2_out, 0);
        check("rst.strobes", {bus.ps2_key_pressed, bus.parity_error, bus.frame_error}, 0);
        check("rst.busy", bus.rx_busy, 0);
        reset = 1'b1;
        cyc_wait(5);

        frame("valid", 8'h1C, 1'b0, 1'b1, -1);
        check("valid.latency", (key_cyc - stop_cyc >= SYNC + FL + 1) && (key_cyc - stop_cyc <= SYNC + FL + 3), 1);
        frame("parity", 8'h1C, 1'b1, 1'b1, -1);
        frame("stop", 8'h5A, 1'b0, 1'b0, -1);
        frame("glitch", 8'h32, 1'b0, 1'b1, 4);

        // Lone falling edge with data high while idle is ignored.
        cyc_wait(HALF);
        bus.ps2_clock = 1'b0;
        cyc_wait(HALF);
        bus.ps2_clock = 1'b1;
        cyc_wait(30);
        check_frame("spurious");

        send(8'h77, 1'b0, 1'b1, 5, -1);
        cyc_wait(20);
        check("tmo.busy_mid", bus.rx_busy, 1);
        cyc_wait(TMO + 50);
        check_frame("tmo");
        frame("after_tmo", 8'h1C, 1'b0, 1'b1, -1);

        frame("brk_f0", 8'hF0, 1'b0, 1'b1, -1);
        frame("brk_1c", 8'h1C, 1'b0, 1'b1, -1);

        send(8'h99, 1'b0, 1'b1, 4, -1);
        reset = 1'b0;
        cyc_wait(2);
        check("midrst.out", bus.ps2_out, 0);
        check("midrst.strobes", {bus.ps2_key_pressed, bus.parity_error, bus.frame_error}, 0);
        check("midrst.busy", bus.rx_busy, 0);
        m_out = 8'h00;
        m_brk = 1'b0;
        bus.ps2_clock = 1'b1;
        cyc_wait(3);
        reset = 1'b1;
        cyc_wait(20);
        frame("post_rst", 8'h45, 1'b0, 1'b1, -1);

        for (int i = 0; i < 30; i++) begin
            b    = ($urandom_range(0, 3) == 0) ? 8'hF0 : 8'($urandom);
            kind = $urandom_range(0, 3);
            g    = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 9) : -1;
            frame("rnd", b, kind == 2, kind != 3, g);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
